// File: rtl/stream_fifo_arbiter_pkg.sv
// Shared state encoding and width helper for the stream FIFO arbiter.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_THROTTLE = 2'd2
  } arb_state_e;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo_arbiter_if.sv
// Requester-side and FIFO-side AXI-stream bundle; master is the arbiter view.
interface stream_fifo_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  logic [NUM_REQ*WIDTH-1:0] in_TDATA;
  logic [NUM_REQ-1:0]       in_TVALID;
  logic [NUM_REQ-1:0]       in_TREADY;
  logic [WIDTH-1:0]         out_TDATA;
  logic                     out_TVALID;
  logic                     out_TREADY;

  modport master (
    input  in_TDATA, in_TVALID, out_TREADY,
    output in_TREADY, out_TDATA, out_TVALID
  );

  modport slave (
    output in_TDATA, in_TVALID, out_TREADY,
    input  in_TREADY, out_TDATA, out_TVALID
  );
endinterface

// File: rtl/stream_fifo_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after last+1, wrapping.
module rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [GW-1:0]      i_last,
  output logic               o_found,
  output logic [GW-1:0]      o_idx
);

  logic [GW-1:0]      w_rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] w_rot;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int offset);
    logic [GW:0] sum;
    sum = {1'b0, base} + (GW+1)'(offset);
    if (sum >= (GW+1)'(NUM_REQ)) begin
      sum = sum - (GW+1)'(NUM_REQ);
    end
    return sum[GW-1:0];
  endfunction

  // Slot gi of the rotated view is the requester gi+1 places after the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign w_rot_idx[gi] = wrap_idx(i_last, gi + 1);
      assign w_rot[gi]     = i_req[w_rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        o_idx   = w_rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Round-robin AXI-stream merge into a FIFO with burst limit, watermark throttling and peak tracking.
module stream_fifo_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 14,
  parameter int BURST   = 16,
  parameter int HIGH_WM = 12288,
  parameter int LOW_WM  = 4096,
  localparam int GW     = clog2(NUM_REQ)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  stream_fifo_arbiter_if.master  bus,
  input  logic [COUNT_W-1:0]     fifo_count,
  input  logic                   clear_peak,
  output logic [GW-1:0]          grant_id,
  output logic                   throttled,
  output logic [COUNT_W-1:0]     peak_count
);

  localparam int         BW         = clog2(BURST + 1);
  localparam logic [1:0] S_IDLE     = ST_IDLE;
  localparam logic [1:0] S_GRANT    = ST_GRANT;
  localparam logic [1:0] S_THROTTLE = ST_THROTTLE;

  logic [1:0]         r_state;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_last;
  logic [BW-1:0]      r_beat_cnt;
  logic [COUNT_W-1:0] r_peak;

  logic          w_sel_found;
  logic [GW-1:0] w_sel_idx;
  logic          w_in_grant;
  logic          w_high;
  logic          w_low;
  logic          w_beat;
  logic          w_burst_end;

  assign w_high      = fifo_count >= COUNT_W'(HIGH_WM);
  assign w_low       = fifo_count <= COUNT_W'(LOW_WM);
  assign w_in_grant  = (r_state == S_GRANT);
  assign w_beat      = bus.out_TVALID & bus.out_TREADY;
  assign w_burst_end = (r_beat_cnt == BW'(BURST - 1));

  assign bus.out_TDATA  = bus.in_TDATA[r_grant*WIDTH +: WIDTH];
  assign bus.out_TVALID = w_in_grant & bus.in_TVALID[r_grant];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign bus.in_TREADY[gi] = w_in_grant && (r_grant == GW'(gi)) && bus.out_TREADY;
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req   (bus.in_TVALID),
    .i_last  (r_last),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  // The grant only moves on a completed beat or when the granted source withdraws.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_last     <= GW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_high) begin
            r_state <= S_THROTTLE;
          end else if (w_sel_found) begin
            r_state    <= S_GRANT;
            r_grant    <= w_sel_idx;
            r_beat_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
            if (w_burst_end || w_high) begin
              r_state <= w_high ? S_THROTTLE : S_IDLE;
              r_last  <= r_grant;
            end
          end else if (!bus.in_TVALID[r_grant]) begin
            r_state <= S_IDLE;
            r_last  <= r_grant;
          end
        end
        S_THROTTLE: begin
          if (w_low) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_peak <= '0;
    end else if (clear_peak) begin
      r_peak <= '0;
    end else if (fifo_count > r_peak) begin
      r_peak <= fifo_count;
    end
  end

  assign grant_id   = r_grant;
  assign throttled  = (r_state == S_THROTTLE);
  assign peak_count = r_peak;

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Directed stimulus with an expected-beat queue drained by an output monitor.
module tb_stream_fifo_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int COUNT_W = 8;
  localparam int BURST   = 4;
  localparam int HIGH_WM = 12;
  localparam int LOW_WM  = 4;

  typedef struct {
    int gid;
    int data;
    int gap;
  } exp_t;

  logic               ap_clk;
  logic               ap_rst_n;
  logic [COUNT_W-1:0] fifo_count;
  logic               clear_peak;
  logic [1:0]         grant_id;
  logic               throttled;
  logic [COUNT_W-1:0] peak_count;

  int   checks;
  int   errors;
  int   src_cnt [NUM_REQ];
  bit   hold_a5;
  exp_t exp_q [$];

  stream_fifo_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  stream_fifo_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W),
    .BURST   (BURST),
    .HIGH_WM (HIGH_WM),
    .LOW_WM  (LOW_WM)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .bus        (bus),
    .fifo_count (fifo_count),
    .clear_peak (clear_peak),
    .grant_id   (grant_id),
    .throttled  (throttled),
    .peak_count (peak_count)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int gid, input int data, input int gap);
    exp_t e;
    e.gid  = gid;
    e.data = data;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic drive_data();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.in_TDATA[i*WIDTH +: WIDTH] = (hold_a5 && i == 1) ? 8'hA5 : {4'(i), 4'(src_cnt[i])};
    end
  endtask

  // One clock: note handshakes mid-cycle, then advance each source after the edge.
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    @(negedge ap_clk);
    hs = bus.in_TVALID & bus.in_TREADY;
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) src_cnt[i]++;
    end
    drive_data();
  endtask

  task automatic wait_drain(input int leave, input string name);
    int n;
    n = 0;
    while (exp_q.size() > leave && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, exp_q.size(), leave);
    while (exp_q.size() > leave) void'(exp_q.pop_back());
  endtask

  initial begin : monitor
    int   cyc;
    int   last_cyc;
    exp_t e;
    cyc      = 0;
    last_cyc = 0;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (bus.out_TVALID && bus.out_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual gid=%0d data=%0h required no beat", grant_id, bus.out_TDATA);
        end else begin
          e = exp_q.pop_front();
          $display("beat gid=%0d data=%0h cycle=%0d", grant_id, bus.out_TDATA, cyc);
          chk("beat_gid", grant_id, e.gid);
          chk("beat_data", bus.out_TDATA, e.data);
          chk("beat_tready", bus.in_TREADY, 1 << e.gid);
          if (e.gap != 0) chk("beat_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin : stimulus
    int grp [5];
    checks         = 0;
    errors         = 0;
    hold_a5        = 1'b0;
    ap_rst_n       = 1'b0;
    fifo_count     = '0;
    clear_peak     = 1'b0;
    bus.in_TVALID  = '0;
    bus.out_TREADY = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_cnt[i] = 0;
    drive_data();

    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_out_tvalid", bus.out_TVALID, 0);
    chk("rst_in_tready", bus.in_TREADY, 0);
    chk("rst_throttled", throttled, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_peak", peak_count, 0);
    bus.in_TVALID = 4'b1111;
    #1;
    chk("rst_in_tready_req", bus.in_TREADY, 0);

    // Full round robin from reset: 0,1,2,3,0 with four beats each.
    tick();
    ap_rst_n = 1'b1;
    grp = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < 4; b++) begin
        push(grp[g], (grp[g] << 4) | ((g == 4 ? 4 : 0) + b), (b != 0) ? 1 : (g == 0 ? 0 : 2));
      end
    end
    wait_drain(0, "t1");
    bus.in_TVALID = '0;
    tick();
    tick();
    chk("t1_idle_tvalid", bus.out_TVALID, 0);
    chk("t1_last_gid", grant_id, 0);

    // Requester 2 abandons after two beats; next grant goes past it to 3.
    bus.in_TVALID = 4'b0100;
    push(2, 8'h24, 0);
    push(2, 8'h25, 1);
    wait_drain(0, "t2a");
    bus.in_TVALID = '0;
    #1;
    chk("t2_drop_tvalid", bus.out_TVALID, 0);
    tick();
    chk("t2_grant_held", grant_id, 2);
    chk("t2_idle_tvalid", bus.out_TVALID, 0);
    bus.in_TVALID = 4'b1011;
    push(3, 8'h34, 0);
    push(3, 8'h35, 1);
    push(3, 8'h36, 1);
    push(3, 8'h37, 1);
    wait_drain(0, "t2b");
    bus.in_TVALID = '0;

    // High watermark mid-burst ends the burst and holds off until the low mark.
    bus.in_TVALID = 4'b0001;
    push(0, 8'h08, 0);
    push(0, 8'h09, 1);
    push(0, 8'h0A, 1);
    wait_drain(1, "t3a");
    fifo_count = 8'd12;
    wait_drain(0, "t3b");
    #1;
    chk("t3_throttled_12", throttled, 1);
    chk("t3_tvalid_12", bus.out_TVALID, 0);
    for (int c = 11; c >= 5; c--) begin
      fifo_count = COUNT_W'(c);
      tick();
      chk("t3_throttled_hold", throttled, 1);
      chk("t3_tvalid_hold", bus.out_TVALID, 0);
    end
    fifo_count    = 8'd4;
    bus.in_TVALID = '0;
    tick();
    chk("t3_released", throttled, 0);

    // Backpressure: stalled cycles hold data and do not count toward the burst.
    hold_a5 = 1'b1;
    drive_data();
    bus.in_TVALID = 4'b0010;
    tick();
    push(1, 8'hA5, 0);
    push(1, 8'hA5, 2);
    push(1, 8'hA5, 3);
    push(1, 8'hA5, 1);
    begin
      bit pat [7];
      pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int p = 0; p < 7; p++) begin
        bus.out_TREADY = pat[p];
        #1;
        if (!pat[p]) begin
          chk("t4_stall_tvalid", bus.out_TVALID, 1);
          chk("t4_stall_tdata", bus.out_TDATA, 8'hA5);
          chk("t4_stall_tready", bus.in_TREADY, 0);
          chk("t4_stall_gid", grant_id, 1);
        end
        tick();
      end
    end
    bus.in_TVALID  = '0;
    bus.out_TREADY = 1'b1;
    #1;
    chk("t4_burst_done", bus.out_TVALID, 0);
    chk("t4_queue", exp_q.size(), 0);
    hold_a5 = 1'b0;
    drive_data();

    // Peak tracking with a clear that wins over a larger sample.
    fifo_count = 8'd3;
    tick();
    chk("t5_peak_keep", peak_count, 12);
    fifo_count = 8'd9;
    clear_peak = 1'b1;
    tick();
    chk("t5_peak_clear", peak_count, 0);
    fifo_count = 8'd7;
    clear_peak = 1'b0;
    tick();
    chk("t5_peak_7", peak_count, 7);
    fifo_count = 8'd0;
    tick();
    chk("t5_peak_hold", peak_count, 7);

    // Reset mid-burst drops the handshake at once and restarts priority at 0.
    bus.in_TVALID = 4'b1111;
    push(2, 8'h26, 0);
    push(2, 8'h27, 1);
    wait_drain(0, "t6a");
    ap_rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", bus.out_TVALID, 0);
    chk("t6_rst_tready", bus.in_TREADY, 0);
    chk("t6_rst_gid", grant_id, 0);
    chk("t6_rst_throttled", throttled, 0);
    chk("t6_rst_peak", peak_count, 0);
    tick();
    ap_rst_n = 1'b1;
    push(0, 8'h0B, 0);
    push(0, 8'h0C, 1);
    push(0, 8'h0D, 1);
    push(0, 8'h0E, 1);
    wait_drain(0, "t6b");
    bus.in_TVALID = '0;

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
